// File: rtl/ddr3_dfi_phy_seq_if.sv
// DFI controller-side bundle of the DDR3 PHY sequencer: command, write and read data channels.
// The controller drives through the master modport; the PHY core uses slave.
interface ddr3_dfi_phy_seq_if #(
   parameter int DQ_LANES = 2
);
   logic [14:0]             dfi_address;
   logic [2:0]              dfi_bank;
   logic                    dfi_ras_n;
   logic                    dfi_cas_n;
   logic                    dfi_we_n;
   logic                    dfi_cs_n;
   logic                    dfi_cke;
   logic                    dfi_odt;
   logic                    dfi_reset_n;
   logic [16*DQ_LANES-1:0]  dfi_wrdata;
   logic [2*DQ_LANES-1:0]   dfi_wrdata_mask;
   logic                    dfi_wrdata_en;
   logic                    dfi_rddata_en;
   logic [16*DQ_LANES-1:0]  dfi_rddata;
   logic                    dfi_rddata_valid;
   logic [1:0]              dfi_rddata_dnv;

   modport master (
      output dfi_address, dfi_bank, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_cs_n,
             dfi_cke, dfi_odt, dfi_reset_n, dfi_wrdata, dfi_wrdata_mask,
             dfi_wrdata_en, dfi_rddata_en,
      input  dfi_rddata, dfi_rddata_valid, dfi_rddata_dnv
   );

   modport slave (
      input  dfi_address, dfi_bank, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_cs_n,
             dfi_cke, dfi_odt, dfi_reset_n, dfi_wrdata, dfi_wrdata_mask,
             dfi_wrdata_en, dfi_rddata_en,
      output dfi_rddata, dfi_rddata_valid, dfi_rddata_dnv
   );
endinterface

// File: rtl/ddr3_dfi_phy_seq.sv
// DDR3 DFI PHY sequencing core: registered command bus, write-latency pipeline with DQ/DQS
// output enables, per-lane read deskew and a sticky write-drive/read-window conflict flag.
module ddr3_dfi_phy_seq #(
   parameter int DQ_LANES   = 2,
   parameter int TPHY_WRLAT = 3,
   parameter int TPHY_RDLAT = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   ddr3_dfi_phy_seq_if.slave       dfi,
   input  logic [2*DQ_LANES-1:0]   lane_rd_dly_i,
   input  logic [16*DQ_LANES-1:0]  pad_rddata_i,
   output logic [13:0]             phy_addr_o,
   output logic [2:0]              phy_ba_o,
   output logic                    phy_ras_n_o,
   output logic                    phy_cas_n_o,
   output logic                    phy_we_n_o,
   output logic                    phy_cs_n_o,
   output logic                    phy_cke_o,
   output logic                    phy_odt_o,
   output logic                    phy_reset_n_o,
   output logic [16*DQ_LANES-1:0]  phy_wrdata_o,
   output logic [2*DQ_LANES-1:0]   phy_wrmask_o,
   output logic [DQ_LANES-1:0]     phy_dq_oe_o,
   output logic [DQ_LANES-1:0]     phy_dqs_oe_o,
   output logic                    conflict_o
);

   localparam int W    = 16*DQ_LANES;
   localparam int M    = 2*DQ_LANES;
   localparam int HALF = 8*DQ_LANES;
   localparam int RDD  = TPHY_RDLAT + 4;

   logic [13:0] addr_q;
   logic [2:0]  ba_q;
   logic        ras_n_q, cas_n_q, we_n_q, cs_n_q, cke_q, odt_q, reset_n_q;

   logic [TPHY_WRLAT-1:0] wr_sr_q;
   logic [W-1:0]          wd_q [TPHY_WRLAT];
   logic [M-1:0]          wm_q [TPHY_WRLAT];
   logic                  post_q;

   logic [RDD-1:0]        rd_sr_q;
   logic [15:0]           dl_q [DQ_LANES][4];
   logic [W-1:0]          aligned;

   logic                  conflict_q, conflict_d;
   logic                  dq_drive, dqs_en, rd_window, rd_valid;
   logic                  addr_unused;

   assign addr_unused = dfi.dfi_address[14];

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         addr_q    <= '0;
         ba_q      <= '0;
         ras_n_q   <= 1'b1;
         cas_n_q   <= 1'b1;
         we_n_q    <= 1'b1;
         cs_n_q    <= 1'b1;
         cke_q     <= 1'b0;
         odt_q     <= 1'b0;
         reset_n_q <= 1'b0;
      end else begin
         addr_q    <= dfi.dfi_address[13:0];
         ba_q      <= dfi.dfi_bank;
         ras_n_q   <= dfi.dfi_ras_n;
         cas_n_q   <= dfi.dfi_cas_n;
         we_n_q    <= dfi.dfi_we_n;
         cs_n_q    <= dfi.dfi_cs_n;
         cke_q     <= dfi.dfi_cke;
         odt_q     <= dfi.dfi_odt;
         reset_n_q <= dfi.dfi_reset_n;
      end
   end

   assign phy_addr_o    = addr_q;
   assign phy_ba_o      = ba_q;
   assign phy_ras_n_o   = ras_n_q;
   assign phy_cas_n_o   = cas_n_q;
   assign phy_we_n_o    = we_n_q;
   assign phy_cs_n_o    = cs_n_q;
   assign phy_cke_o     = cke_q;
   assign phy_odt_o     = odt_q;
   assign phy_reset_n_o = reset_n_q;

   // Write enable, data and mask travel together so the pad drive lines up with its payload.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_sr_q <= '0;
         post_q  <= 1'b0;
         for (int k = 0; k < TPHY_WRLAT; k++) begin
            wd_q[k] <= '0;
            wm_q[k] <= '1;
         end
      end else begin
         wr_sr_q <= {wr_sr_q[TPHY_WRLAT-2:0], dfi.dfi_wrdata_en};
         post_q  <= dq_drive;
         wd_q[0] <= dfi.dfi_wrdata;
         wm_q[0] <= dfi.dfi_wrdata_mask;
         for (int k = 1; k < TPHY_WRLAT; k++) begin
            wd_q[k] <= wd_q[k-1];
            wm_q[k] <= wm_q[k-1];
         end
      end
   end

   assign dq_drive     = wr_sr_q[TPHY_WRLAT-1];
   assign dqs_en       = wr_sr_q[TPHY_WRLAT-2] | dq_drive | post_q;
   assign phy_dq_oe_o  = {DQ_LANES{dq_drive}};
   assign phy_dqs_oe_o = {DQ_LANES{dqs_en}};
   assign phy_wrdata_o = dq_drive ? wd_q[TPHY_WRLAT-1] : '0;
   assign phy_wrmask_o = dq_drive ? wm_q[TPHY_WRLAT-1] : '1;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rd_sr_q <= '0;
         for (int l = 0; l < DQ_LANES; l++) begin
            for (int k = 0; k < 4; k++) begin
               dl_q[l][k] <= '0;
            end
         end
      end else begin
         rd_sr_q <= {rd_sr_q[RDD-2:0], dfi.dfi_rddata_en};
         for (int l = 0; l < DQ_LANES; l++) begin
            dl_q[l][0] <= {pad_rddata_i[HALF+8*l +: 8], pad_rddata_i[8*l +: 8]};
            for (int k = 1; k < 4; k++) begin
               dl_q[l][k] <= dl_q[l][k-1];
            end
         end
      end
   end

   // A lane arriving dly cycles late needs 4-dly cycles of delay, i.e. tap 3-dly.
   always_comb begin
      aligned = '0;
      for (int l = 0; l < DQ_LANES; l++) begin
         logic [1:0]  tap;
         logic [15:0] word;
         tap  = 2'd3 - lane_rd_dly_i[2*l +: 2];
         word = dl_q[l][tap];
         aligned[8*l +: 8]      = word[7:0];
         aligned[HALF+8*l +: 8] = word[15:8];
      end
   end

   assign rd_valid             = rd_sr_q[RDD-1];
   assign dfi.dfi_rddata_valid = rd_valid;
   assign dfi.dfi_rddata       = rd_valid ? aligned : '0;
   assign dfi.dfi_rddata_dnv   = 2'b00;

   // Pad window of a request at t spans t+RDLAT..t+RDLAT+3; rd_sr_q[k] holds the request from c-1-k.
   assign rd_window  = |rd_sr_q[TPHY_RDLAT+2:TPHY_RDLAT-1];
   assign conflict_d = conflict_q | (dqs_en & rd_window);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         conflict_q <= 1'b0;
      end else begin
         conflict_q <= conflict_d;
      end
   end

   assign conflict_o = conflict_q;

endmodule

// File: tb/tb_ddr3_dfi_phy_seq.sv
// Self-checking bench for ddr3_dfi_phy_seq: directed write/read/conflict/reset scenarios
// followed by random traffic, all compared against a cycle-history reference model.
module tb_ddr3_dfi_phy_seq;

   localparam int L    = 2;
   localparam int WRL  = 3;
   localparam int RDL  = 4;
   localparam int W    = 16*L;
   localparam int M    = 2*L;
   localparam int MAXC = 1024;

   logic clk = 1'b0;
   logic rstN;
   always #5 clk = ~clk;

   ddr3_dfi_phy_seq_if #(.DQ_LANES(L)) dfiIf ();

   logic [M-1:0]  laneDly;
   logic [W-1:0]  padData;
   logic [13:0]   phyAddr;
   logic [2:0]    phyBa;
   logic          phyRasN, phyCasN, phyWeN, phyCsN, phyCke, phyOdt, phyResetN;
   logic [W-1:0]  phyWrdata;
   logic [M-1:0]  phyWrmask;
   logic [L-1:0]  phyDqOe, phyDqsOe;
   logic          conflict;

   ddr3_dfi_phy_seq #(.DQ_LANES(L), .TPHY_WRLAT(WRL), .TPHY_RDLAT(RDL)) dut (
      .clk_i         (clk),
      .rst_n_i       (rstN),
      .dfi           (dfiIf),
      .lane_rd_dly_i (laneDly),
      .pad_rddata_i  (padData),
      .phy_addr_o    (phyAddr),
      .phy_ba_o      (phyBa),
      .phy_ras_n_o   (phyRasN),
      .phy_cas_n_o   (phyCasN),
      .phy_we_n_o    (phyWeN),
      .phy_cs_n_o    (phyCsN),
      .phy_cke_o     (phyCke),
      .phy_odt_o     (phyOdt),
      .phy_reset_n_o (phyResetN),
      .phy_wrdata_o  (phyWrdata),
      .phy_wrmask_o  (phyWrmask),
      .phy_dq_oe_o   (phyDqOe),
      .phy_dqs_oe_o  (phyDqsOe),
      .conflict_o    (conflict)
   );

   // Input history of the current reset epoch, indexed by cycle number since release.
   logic          wenH [MAXC];
   logic          renH [MAXC];
   logic [W-1:0]  wdH  [MAXC];
   logic [M-1:0]  wmH  [MAXC];
   logic [W-1:0]  padH [MAXC];
   logic [23:0]   cmdH [MAXC];
   int            cyc;
   logic          expConflict;
   int            checks;
   int            errors;

   localparam logic [23:0] CMD_RESET = {14'h0, 3'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

   function automatic logic [W-1:0] randW();
      logic [W-1:0] v;
      v = '0;
      repeat ((W+31)/32) v = (v << 32) | W'($urandom());
      return v;
   endfunction

   function automatic logic histWen(input int c);
      return (c >= 0) ? wenH[c] : 1'b0;
   endfunction

   function automatic logic histRen(input int c);
      return (c >= 0) ? renH[c] : 1'b0;
   endfunction

   task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic wen, input logic ren, input logic [W-1:0] wd,
                                input logic [M-1:0] wm, input logic [W-1:0] pad,
                                input logic [24:0] cmdIn);
      dfiIf.dfi_address     = cmdIn[24:10];
      dfiIf.dfi_bank        = cmdIn[9:7];
      dfiIf.dfi_ras_n       = cmdIn[6];
      dfiIf.dfi_cas_n       = cmdIn[5];
      dfiIf.dfi_we_n        = cmdIn[4];
      dfiIf.dfi_cs_n        = cmdIn[3];
      dfiIf.dfi_cke         = cmdIn[2];
      dfiIf.dfi_odt         = cmdIn[1];
      dfiIf.dfi_reset_n     = cmdIn[0];
      dfiIf.dfi_wrdata      = wd;
      dfiIf.dfi_wrdata_mask = wm;
      dfiIf.dfi_wrdata_en   = wen;
      dfiIf.dfi_rddata_en   = ren;
      padData               = pad;
      if (rstN === 1'b1) begin
         wenH[cyc] = wen;
         renH[cyc] = ren;
         wdH[cyc]  = wd;
         wmH[cyc]  = wm;
         padH[cyc] = pad;
         cmdH[cyc] = cmdIn[23:0];
      end
   endtask

   task automatic randApply(input logic wen, input logic ren);
      applyStimulus(wen, ren, randW(), M'($urandom()), randW(), 25'($urandom()));
   endtask

   // Reference: every output is derived from the input history using the documented latencies.
   task automatic checkOutput();
      int            c;
      logic          expDrive, expDqs, expValid, inWin;
      logic [W-1:0]  expWd, expRd;
      logic [M-1:0]  expWm;
      logic [23:0]   expCmd;
      @(negedge clk);
      c        = cyc;
      expDrive = histWen(c-WRL);
      expDqs   = histWen(c-WRL+1) | expDrive | histWen(c-WRL-1);
      expWd    = '0;
      expWm    = '1;
      if (expDrive) begin
         expWd = wdH[c-WRL];
         expWm = wmH[c-WRL];
      end
      expValid = histRen(c-RDL-4);
      expRd    = '0;
      if (expValid) begin
         for (int l = 0; l < L; l++) begin
            int src;
            src = c - (4 - int'(laneDly[2*l +: 2]));
            if (src >= 0) begin
               expRd[8*l +: 8]     = padH[src][8*l +: 8];
               expRd[W/2+8*l +: 8] = padH[src][W/2+8*l +: 8];
            end
         end
      end
      expCmd = (c >= 1) ? cmdH[c-1] : CMD_RESET;
      checkVal("dq_oe",    phyDqOe, {L{expDrive}});
      checkVal("dqs_oe",   phyDqsOe, {L{expDqs}});
      checkVal("wrdata",   phyWrdata, expWd);
      checkVal("wrmask",   phyWrmask, expWm);
      checkVal("rd_valid", dfiIf.dfi_rddata_valid, expValid);
      checkVal("rddata",   dfiIf.dfi_rddata, expRd);
      checkVal("rd_dnv",   dfiIf.dfi_rddata_dnv, 2'b00);
      checkVal("conflict", conflict, expConflict);
      checkVal("cmd", {phyAddr, phyBa, phyRasN, phyCasN, phyWeN, phyCsN, phyCke, phyOdt, phyResetN},
               expCmd);
      inWin = 1'b0;
      for (int k = 0; k < 4; k++) inWin = inWin | histRen(c-RDL-k);
      if (expDqs && inWin) expConflict = 1'b1;
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic step(input logic wen, input logic ren);
      randApply(wen, ren);
      checkOutput();
      advance();
   endtask

   task automatic runTo(input int target);
      while (cyc < target) step(1'b0, 1'b0);
   endtask

   task automatic stepExpectDqs(input logic wen, input logic dqs);
      randApply(wen, 1'b0);
      checkOutput();
      checkVal("dqs_window", phyDqsOe, {L{dqs}});
      advance();
   endtask

   task automatic checkReset();
      checkVal("rst_cmd", {phyAddr, phyBa, phyRasN, phyCasN, phyWeN, phyCsN, phyCke, phyOdt, phyResetN},
               CMD_RESET);
      checkVal("rst_wrdata", phyWrdata, '0);
      checkVal("rst_wrmask", phyWrmask, {M{1'b1}});
      checkVal("rst_oe", {phyDqOe, phyDqsOe}, '0);
      checkVal("rst_rd", {dfiIf.dfi_rddata, dfiIf.dfi_rddata_valid}, '0);
      checkVal("rst_conflict", conflict, 1'b0);
   endtask

   task automatic resetPhase(input int n);
      rstN = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
         randApply($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
         @(negedge clk);
         checkReset();
      end
      @(posedge clk);
      #1;
      rstN        = 1'b1;
      cyc         = 0;
      expConflict = 1'b0;
   endtask

   initial begin
      logic [8:0]  g1W, g1D;
      logic [9:0]  g2W, g2D;
      logic [24:0] cmdIn;
      checks      = 0;
      errors      = 0;
      cyc         = 0;
      expConflict = 1'b0;
      rstN        = 1'b0;
      laneDly     = 4'b10_00;
      applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);

      $display("[TB] reset with toggling inputs");
      resetPhase(4);

      cmdIn = 25'($urandom()) & ~25'h48;
      applyStimulus(1'b0, 1'b0, randW(), M'($urandom()), randW(), cmdIn);
      checkOutput();
      advance();
      randApply(1'b0, 1'b0);
      checkOutput();
      checkVal("cmd_cs_n",  phyCsN, 1'b0);
      checkVal("cmd_ras_n", phyRasN, 1'b0);
      advance();

      $display("[TB] single write");
      runTo(10);
      applyStimulus(1'b1, 1'b0, W'(32'hA5A5_5A5A), '0, randW(), 25'($urandom()));
      checkOutput();
      advance();
      stepExpectDqs(1'b0, 1'b0);
      stepExpectDqs(1'b0, 1'b1);
      randApply(1'b0, 1'b0);
      checkOutput();
      checkVal("wr_dq_oe",  phyDqOe, {L{1'b1}});
      checkVal("wr_dqs_oe", phyDqsOe, {L{1'b1}});
      checkVal("wr_data",   phyWrdata, W'(32'hA5A5_5A5A));
      checkVal("wr_mask",   phyWrmask, '0);
      advance();
      randApply(1'b0, 1'b0);
      checkOutput();
      checkVal("post_data", phyWrdata, '0);
      checkVal("post_mask", phyWrmask, M'(4'hF));
      checkVal("post_dqs",  phyDqsOe, {L{1'b1}});
      advance();
      stepExpectDqs(1'b0, 1'b0);

      $display("[TB] write gaps");
      g1W = 9'b000001011;
      g1D = 9'b011111100;
      runTo(30);
      for (int k = 0; k < 9; k++) stepExpectDqs(g1W[k], g1D[k]);
      g2W = 10'b0000010001;
      g2D = 10'b0111011100;
      runTo(40);
      for (int k = 0; k < 10; k++) stepExpectDqs(g2W[k], g2D[k]);

      $display("[TB] read deskew");
      runTo(60);
      step(1'b0, 1'b1);
      runTo(64);
      applyStimulus(1'b0, 1'b0, randW(), M'($urandom()),
                    {8'($urandom()), 8'h22, 8'($urandom()), 8'h11}, 25'($urandom()));
      checkOutput();
      advance();
      step(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, randW(), M'($urandom()),
                    {8'h44, 8'($urandom()), 8'h33, 8'($urandom())}, 25'($urandom()));
      checkOutput();
      advance();
      randApply(1'b0, 1'b0);
      checkOutput();
      checkVal("rd_valid_early", dfiIf.dfi_rddata_valid, 1'b0);
      advance();
      randApply(1'b0, 1'b0);
      checkOutput();
      checkVal("rd_valid_hit", dfiIf.dfi_rddata_valid, 1'b1);
      checkVal("rd_data_hit",  dfiIf.dfi_rddata, W'(32'h4422_3311));
      advance();
      randApply(1'b0, 1'b0);
      checkOutput();
      checkVal("rd_valid_late", dfiIf.dfi_rddata_valid, 1'b0);
      advance();
      runTo(70);
      randApply(1'b0, 1'b0);
      checkOutput();
      checkVal("no_conflict", conflict, 1'b0);
      advance();

      $display("[TB] conflict");
      runTo(80);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      runTo(84);
      randApply(1'b0, 1'b0);
      checkOutput();
      checkVal("conflict_pre", conflict, 1'b0);
      advance();
      randApply(1'b0, 1'b0);
      checkOutput();
      checkVal("conflict_set", conflict, 1'b1);
      advance();
      runTo(90);
      randApply(1'b0, 1'b0);
      checkOutput();
      checkVal("conflict_hold", conflict, 1'b1);
      advance();

      $display("[TB] reset mid-burst");
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      randApply(1'b0, 1'b0);
      checkOutput();
      checkVal("burst_dq_oe", phyDqOe, {L{1'b1}});
      #1;
      rstN = 1'b0;
      #1;
      checkVal("async_dq_oe",  phyDqOe, '0);
      checkVal("async_dqs_oe", phyDqsOe, '0);
      checkVal("async_conf",   conflict, 1'b0);
      resetPhase(2);
      for (int k = 0; k < 12; k++) step(1'b0, 1'b0);

      $display("[TB] random traffic");
      for (int e = 0; e < 3; e++) begin
         laneDly = M'($urandom());
         resetPhase(2);
         for (int k = 0; k < 150; k++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ddr3_dfi_phy_seq.md
# ddr3_dfi_phy_seq

Technology-independent sequencing core for the next-generation DDR3 DFI PHY. It sits between the DFI controller and the vendor IO wrappers (DDR output/input registers, bidirectional pads). It registers the command bus and delays write data by a programmable write latency. It generates DQ/DQS output enables with DQS preamble/postamble, and aligns per-byte-lane read data with programmable deskew. A sticky flag reports write-drive/read-window bus conflicts.

## Interface
- DQ_LANES, 2: number of byte lanes (1..8); data width per clk is 16*DQ_LANES (8 bits x 2 edges per lane)
- TPHY_WRLAT, 3: cycles from dfi_wrdata_en_i to pad DQ drive (>= 2)
- TPHY_RDLAT, 4: cycles from dfi_rddata_en_i to earliest pad read data (>= 1)

Ports:
- clk_i  in  1  PHY clock; all logic on rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- dfi_address_i  in  15  row/column address; bits [13:0] used
- dfi_bank_i  in  3  bank
- dfi_ras_n_i, dfi_cas_n_i, dfi_we_n_i, dfi_cs_n_i  in  1 each  command strobes
- dfi_cke_i, dfi_odt_i, dfi_reset_n_i  in  1 each  control
- dfi_wrdata_i  in  16*DQ_LANES  write data; low half = rising edge, high half = falling edge; lane l occupies bits [8l+7:8l] of each half
- dfi_wrdata_mask_i  in  2*DQ_LANES  byte mask, same half/lane layout
- dfi_wrdata_en_i  in  1  write data valid (data accompanies enable)
- dfi_rddata_en_i  in  1  read request
- lane_rd_dly_i  in  2*DQ_LANES  per-lane read arrival offset 0..3 cycles; quasi-static
- pad_rddata_i  in  16*DQ_LANES  captured data from the input DDR registers, same layout
- phy_addr_o  out  14;  phy_ba_o  out  3;  phy_ras_n_o, phy_cas_n_o, phy_we_n_o, phy_cs_n_o, phy_cke_o, phy_odt_o, phy_reset_n_o  out  1 each  registered command
- phy_wrdata_o  out  16*DQ_LANES  write data to DDR output registers
- phy_wrmask_o  out  2*DQ_LANES  write mask to DDR output registers
- phy_dq_oe_o  out  DQ_LANES  DQ/DM pad output enable per lane
- phy_dqs_oe_o  out  DQ_LANES  DQS pad output enable per lane
- dfi_rddata_o  out  16*DQ_LANES  aligned read data
- dfi_rddata_valid_o  out  1  read data valid
- dfi_rddata_dnv_o  out  2  tied 0
- conflict_o  out  1  sticky bus-conflict flag

## Operation
- Reset (async assert, sync-timed deassert by the caller) drives: phy_cs_n/ras_n/cas_n/we_n = 1 (NOP), phy_cke = 0, phy_reset_n = 0, phy_odt = 0, addr/ba = 0, wrdata = 0, wrmask = all 1, all OE = 0, rddata = 0, valid = 0, conflict = 0. All pipelines clear. Assertion mid-burst drops OEs immediately.
- Command path: a single register stage. Address is truncated to [13:0].
- Write path: wr_sr is a TPHY_WRLAT-deep shift register of dfi_wrdata_en_i, with data and mask pipelined alongside.
  - dq_drive = wr_sr[TPHY_WRLAT-1].
  - phy_dq_oe_o = {DQ_LANES{dq_drive}}.
  - phy_wrdata_o = delayed data when dq_drive, else 0.
  - phy_wrmask_o = delayed mask when dq_drive, else all 1.
- DQS enable = preamble | dq_drive | postamble, all lanes equal.
  - preamble = wr_sr[TPHY_WRLAT-2].
  - postamble = dq_drive of the previous cycle.
  - Bursts with a 1-cycle gap merge into continuous DQS enable. A gap of 2 or more cycles gives separate windows.
- Read path:
  - rd_sr carries dfi_rddata_en_i for TPHY_RDLAT+4 cycles.
  - Lane l: a 4-deep delay line of the pad_rddata_i lane slice. The tap is chosen so that output in cycle c = pad input in cycle c-(4-lane_rd_dly_i[l]).
  - dfi_rddata_valid_o in cycle c = dfi_rddata_en_i in cycle c-(TPHY_RDLAT+4).
  - dfi_rddata_o is the aligned data when valid, else 0.
  - Changing lane_rd_dly_i with a read in flight corrupts only that read's data; valid timing is unaffected.
- Conflict: the read pad window of a request issued at cycle t is cycles t+TPHY_RDLAT .. t+TPHY_RDLAT+3. conflict_o is set if phy_dqs_oe_o is high in any cycle inside an active read window. It is cleared only by reset. Writes and reads still proceed.

## Timing
- Command latency: 1 cycle.
- Write en at cycle t: DQS OE high t+WRLAT-1 .. t+WRLAT+1; DQ OE and data in cycle t+WRLAT.
- Read en at cycle t: lane l expected at pad in cycle t+RDLAT+dly_l; dfi_rddata_o/valid in cycle t+RDLAT+4.
- Back-to-back enables stream every cycle; no stall, no backpressure.
- Simultaneous wrdata_en and rddata_en are both accepted; conflict detection covers the case.

## Test plan
- Reset: hold rst_n_i=0, toggle all inputs -> every output at the listed reset value. Release -> dfi_cs_n_i=0, ras_n=0 appears on phy_* one cycle later.
- Single write (WRLAT=3): en at t=10, data 0xA5A5_5A5A, mask 0 -> DQS OE cycles 12-14, DQ OE + data + mask 0 in cycle 13, wrdata 0 and mask 0xF elsewhere.
- Write gaps: en at 10-11 and 13 -> DQS OE continuous 12-17. En at 10 and 14 -> DQS OE 12-14 and 16-18.
- Read deskew (RDLAT=4, DQ_LANES=2, dly={2,0}): en at t=20, lane0 pad 0x11/0x22 in cycle 24, lane1 0x33/0x44 in cycle 26 -> cycle 28: valid=1, rddata={0x44,0x22,0x33,0x11}. Valid=0 at cycles 27 and 29.
- Conflict: read en at 20, write en at 22 (DQS OE 24-26) -> conflict_o=1 from cycle 25, held until reset. Non-overlapping traffic -> stays 0.
- Reset mid-burst: assert rst_n_i during DQ OE -> OEs fall without a clock edge; after release, no stale valid or write drive.
